// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding
// and the default operand width.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// One-bit full adder: sum bit and carry (majority of the three inputs).
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell reused over WIDTH cycles,
// with registered sum/cout/ovf published on entry to DONE.
module bit_serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .a  (areg[0]),
    .b  (breg[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      areg  <= '0;
      breg  <= '0;
      sreg  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            areg  <= a;
            breg  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          sreg  <= {fa_s, sreg[WIDTH-1:1]};
          carry <= fa_co;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this last bit
            sum   <= {fa_s, sreg[WIDTH-1:1]};
            cout  <= fa_co;
            ovf   <= carry ^ fa_co;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
